exec_mem_unit: RTL and testbench
================================

Name: exec_mem_unit

Overview:
- Execute/memory slice of the rv32i single-cycle core: 32-bit ALU, byte-addressed data BRAM, and load-result byte reader.
- The ALU result is both the branch/compare value and the data-memory byte address.
- The memory read path is combinational, so a load completes in the same cycle; stores commit on the clock edge.
- An init mux lets the host preload memory before the core takes over.

Parameters:
- DATA_WIDTH, 32, datapath width.
- ADDR_WIDTH, 12, byte-address width of memory ports.
- DEPTH, 1024, number of 32-bit memory words.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- alu_ctrl  input  4  ALU operation select.
- alu_src  input  1  0: operand B = src2; 1: operand B = sign_ext.
- src1  input  32  operand A (rs1).
- src2  input  32  rs2 value.
- sign_ext  input  32  sign-extended immediate.
- func3  input  3  load width/sign select.
- mem_read  input  1  read enable.
- mem_write  input  1  core write enable.
- byte_enb  input  4  core byte-lane mask; used for both store and load lane select.
- mem_write_data  input  32  lane-aligned store data.
- init_done  input  1  0: host init port drives the write port; 1: core drives it.
- init_addr  input  12  host byte address.
- init_dat  input  32  host data.
- init_enb  input  1  host write enable.
- init_byte_enb  input  4  host lane mask.
- debug_addr  input  12  debug read byte address.
- results  output  32  ALU result.
- zero  output  1  high when results == 0.
- res_last_bit  output  1  results[0].
- wb_data  output  32  load write-back value.
- valid  output  1  wb_data is legal.
- debug_data  output  32  word at debug_addr.

Behaviour:
- ALU is purely combinational. B = alu_src ? sign_ext : src2.
- ALU op encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is B[4:0].
  - 1000 SLT (signed), 1001 SLTU (unsigned); both give 0 or 1.
  - Any other code gives 0.
- Arithmetic wraps modulo 2^32; there is no overflow flag.
- Memory: DEPTH x 32 array; word index = byte address [11:2]; address bits above 11 are ignored.
- Write port mux:
  - init_done=0: address init_addr, data init_dat, enable init_enb, mask init_byte_enb.
  - init_done=1: address {results[11:2],00}, data mem_write_data, enable mem_write, mask byte_enb.
- Writes are synchronous on the rising clk edge and update only lanes whose mask bit is 1 (bit0 = bits[7:0]).
- Read is combinational from word results[11:2] when mem_read=1; otherwise the raw read word is 0.
- A same-cycle write to the word being read returns the old contents until the edge.
- debug_data is always the combinational word at debug_addr[11:2].
- While rst=0, the raw read word and wb_data are forced to 0 and writes are blocked. Array contents are never cleared by reset. Release takes effect immediately.
- Byte reader, from the raw read word R:
  - 000 LB: mask must be one-hot; selected byte is sign-extended.
  - 100 LBU: mask must be one-hot; selected byte is zero-extended.
  - 001 LH: mask must be 0011 (R[15:0]) or 1100 (R[31:16]); sign-extended.
  - 101 LHU: same masks as LH; zero-extended.
  - 010 LW: mask must be 1111; result is R.
  - Any other func3/mask combination: valid=0, wb_data=0.
- valid=1 for every legal combination, independent of mem_read.
- There is no internal FSM. The only state is the memory array. All outputs are combinational except the write commit.

Test Plan:
1. SUB with src1=1, src2=1 -> results=0, zero=1. SUB with src1=1, src2=3 -> results=FFFFFFFE, zero=0, res_last_bit=0 (bne-taken case).
2. Preload via init port: words 0,4,8 = 1,3,5; then init_done=1 -> ADD with src1=0, sign_ext=8, mem_read=1, func3=010, mask 1111 -> wb_data=00000005, valid=1.
3. Store: ADD results=0xC, mem_write=1, mask 1111, data 5; after the clock edge, debug_addr=0xC -> debug_data=00000005. Masked store with 0010, data 0x0000AB00 -> only byte1 changes.
4. Word=0x80FF7F01: LB mask 0100 -> FFFFFFFF; LBU mask 1000 -> 00000080; LH mask 1100 -> FFFF80FF; LHU mask 0011 -> 00007F01. func3=011 -> valid=0, wb_data=0.
5. ALU sweep: SRA 0x80000000>>4 -> F8000000; SLT -1<1 -> 1; SLTU FFFFFFFF<1 -> 0; alu_src=1 selects sign_ext; unused code 1111 -> 0.
6. Assert rst mid-run -> wb_data=0 immediately and a write during reset is blocked; after release, previously stored words read back intact.

Source files
------------

// File: rtl/exec_mem_unit.sv
// rtl/exec_mem_unit.sv - rv32i execute/memory slice: ALU, byte-lane data RAM, load byte reader
module exec_mem_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            alu_ctrl,
    input  logic                  alu_src,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic [DATA_WIDTH-1:0] sign_ext,
    input  logic [2:0]            func3,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [3:0]            byte_enb,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  init_done,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0] init_dat,
    input  logic                  init_enb,
    input  logic [3:0]            init_byte_enb,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] results,
    output logic                  zero,
    output logic                  res_last_bit,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] debug_data
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    logic [DATA_WIDTH-1:0] alu_b;
    logic [4:0]            shamt;

    assign alu_b = alu_src ? sign_ext : src2;
    assign shamt = alu_b[4:0];

    always_comb begin
        results = '0;
        case (alu_ctrl)
            OP_ADD:  results = src1 + alu_b;
            OP_SUB:  results = src1 - alu_b;
            OP_AND:  results = src1 & alu_b;
            OP_OR:   results = src1 | alu_b;
            OP_XOR:  results = src1 ^ alu_b;
            OP_SLL:  results = src1 << shamt;
            OP_SRL:  results = src1 >> shamt;
            OP_SRA:  results = $unsigned($signed(src1) >>> shamt);
            OP_SLT:  results = {{(DATA_WIDTH-1){1'b0}}, $signed(src1) < $signed(alu_b)};
            OP_SLTU: results = {{(DATA_WIDTH-1){1'b0}}, src1 < alu_b};
            default: results = '0;
        endcase
    end

    assign zero         = (results == '0);
    assign res_last_bit = results[0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            wr_mask;
    logic                  wr_en;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      dbg_idx;

    // Host owns the write port until init_done; the core then addresses by ALU result.
    always_comb begin
        if (init_done) begin
            wr_idx  = results[IDX_W+1:2];
            wr_data = mem_write_data;
            wr_mask = byte_enb;
            wr_en   = mem_write;
        end else begin
            wr_idx  = init_addr[IDX_W+1:2];
            wr_data = init_dat;
            wr_mask = init_byte_enb;
            wr_en   = init_enb;
        end
    end

    // Array has no reset: contents survive rst, only the write strobe is gated.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_idx  = results[IDX_W+1:2];
    assign dbg_idx = debug_addr[IDX_W+1:2];

    logic [DATA_WIDTH-1:0] raw_word;

    assign raw_word   = (rst && mem_read) ? mem_q[rd_idx] : '0;
    assign debug_data = mem_q[dbg_idx];

    logic [DATA_WIDTH-1:0] load_val;
    logic                  load_ok;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;

    always_comb begin
        load_val = '0;
        load_ok  = 1'b0;
        sel_byte = '0;
        sel_half = '0;
        case (func3)
            3'b000, 3'b100: begin
                load_ok = 1'b1;
                case (byte_enb)
                    4'b0001: sel_byte = raw_word[7:0];
                    4'b0010: sel_byte = raw_word[15:8];
                    4'b0100: sel_byte = raw_word[23:16];
                    4'b1000: sel_byte = raw_word[31:24];
                    default: load_ok  = 1'b0;
                endcase
                load_val = func3[2] ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            3'b001, 3'b101: begin
                load_ok = 1'b1;
                case (byte_enb)
                    4'b0011: sel_half = raw_word[15:0];
                    4'b1100: sel_half = raw_word[31:16];
                    default: load_ok  = 1'b0;
                endcase
                load_val = func3[2] ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            3'b010: begin
                load_ok  = (byte_enb == 4'b1111);
                load_val = raw_word;
            end
            default: begin
                load_ok  = 1'b0;
                load_val = '0;
            end
        endcase
    end

    assign valid   = load_ok;
    assign wb_data = (load_ok && rst) ? load_val : '0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// tb/tb_exec_mem_unit.sv - directed vector bench for exec_mem_unit
module tb_exec_mem_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic [31:0] src1, src2, sign_ext;
    logic [2:0]  func3;
    logic        mem_read, mem_write;
    logic [3:0]  byte_enb;
    logic [31:0] mem_write_data;
    logic        init_done;
    logic [11:0] init_addr;
    logic [31:0] init_dat;
    logic        init_enb;
    logic [3:0]  init_byte_enb;
    logic [11:0] debug_addr;
    logic [31:0] results, wb_data, debug_data;
    logic        zero, res_last_bit, valid;

    int n_checks = 0;
    int n_fail   = 0;

    exec_mem_unit dut (
        .clk(clk), .rst(rst), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
        .src1(src1), .src2(src2), .sign_ext(sign_ext), .func3(func3),
        .mem_read(mem_read), .mem_write(mem_write), .byte_enb(byte_enb),
        .mem_write_data(mem_write_data), .init_done(init_done),
        .init_addr(init_addr), .init_dat(init_dat), .init_enb(init_enb),
        .init_byte_enb(init_byte_enb), .debug_addr(debug_addr),
        .results(results), .zero(zero), .res_last_bit(res_last_bit),
        .wb_data(wb_data), .valid(valid), .debug_data(debug_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic        src;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Sets up an ALU ADD of addr+0 so results drives the memory address.
    task automatic set_addr(input logic [31:0] addr);
        alu_ctrl = 4'b0000;
        alu_src  = 1'b1;
        src1     = addr;
        sign_ext = 32'h0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [2:0] f3, input logic [3:0] m);
        set_addr(addr);
        mem_read = 1'b1;
        func3    = f3;
        byte_enb = m;
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        set_addr(addr);
        mem_write      = 1'b1;
        mem_write_data = d;
        byte_enb       = m;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic host_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        init_addr     = a;
        init_dat      = d;
        init_enb      = 1'b1;
        init_byte_enb = 4'b1111;
        @(posedge clk);
        #1;
        init_enb = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 1'b0, 32'h1,        32'h1,        32'h0,        32'h0};
        vecs[1]  = '{4'b0001, 1'b0, 32'h1,        32'h3,        32'h0,        32'hFFFFFFFE};
        vecs[2]  = '{4'b0000, 1'b0, 32'h7FFFFFFF, 32'h1,        32'h0,        32'h80000000};
        vecs[3]  = '{4'b0000, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0};
        vecs[4]  = '{4'b0010, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000};
        vecs[5]  = '{4'b0011, 1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0,        32'hFFFFF0F0};
        vecs[6]  = '{4'b0100, 1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        32'hF0F00F0F};
        vecs[7]  = '{4'b0101, 1'b0, 32'h1,        32'h1F,       32'h0,        32'h80000000};
        vecs[8]  = '{4'b0101, 1'b0, 32'h1,        32'h24,       32'h0,        32'h10};
        vecs[9]  = '{4'b0110, 1'b0, 32'h80000000, 32'h4,        32'h0,        32'h08000000};
        vecs[10] = '{4'b0111, 1'b0, 32'h80000000, 32'h4,        32'h0,        32'hF8000000};
        vecs[11] = '{4'b1000, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h1};
        vecs[12] = '{4'b1001, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0};
        vecs[13] = '{4'b0000, 1'b1, 32'h10,       32'hFFFF,     32'hFFFFFFFC, 32'hC};
        vecs[14] = '{4'b1111, 1'b0, 32'h5,        32'h3,        32'h0,        32'h0};
        vecs[15] = '{4'b1010, 1'b0, 32'h5,        32'h3,        32'h0,        32'h0};

        rst = 1'b0; alu_ctrl = 4'b0; alu_src = 1'b0; src1 = '0; src2 = '0; sign_ext = '0;
        func3 = 3'b010; mem_read = 1'b1; mem_write = 1'b0; byte_enb = 4'b1111;
        mem_write_data = '0; init_done = 1'b0; init_addr = '0; init_dat = '0;
        init_enb = 1'b0; init_byte_enb = 4'b0; debug_addr = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_wb_data", wb_data, 32'h0);
        check("reset_valid_lw", {31'h0, valid}, 32'h1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            alu_ctrl = vecs[i].ctrl;
            alu_src  = vecs[i].src;
            src1     = vecs[i].a;
            src2     = vecs[i].b;
            sign_ext = vecs[i].imm;
            #1;
            check($sformatf("alu_results[%0d]", i), results, vecs[i].exp);
            check($sformatf("alu_zero[%0d]", i), {31'h0, zero}, {31'h0, vecs[i].exp == 32'h0});
            check($sformatf("alu_lsb[%0d]", i), {31'h0, res_last_bit}, {31'h0, vecs[i].exp[0]});
        end

        host_write(12'h000, 32'h1);
        host_write(12'h004, 32'h3);
        host_write(12'h008, 32'h5);
        init_done = 1'b1;
        load(32'h8, 3'b010, 4'b1111);
        check("preload_lw8", wb_data, 32'h5);
        check("preload_valid", {31'h0, valid}, 32'h1);
        load(32'h4, 3'b010, 4'b1111);
        check("preload_lw4", wb_data, 32'h3);
        load(32'h1008, 3'b010, 4'b1111);
        check("addr_high_ignored", wb_data, 32'h5);
        mem_read = 1'b0;
        #1;
        check("no_read_zero", wb_data, 32'h0);

        store(32'hC, 32'h5, 4'b1111);
        debug_addr = 12'h00C;
        #1;
        check("store_debug", debug_data, 32'h5);
        store(32'hC, 32'h0000AB00, 4'b0010);
        #1;
        check("masked_store", debug_data, 32'h0000AB05);

        // Read and write the same word in one cycle: old data until the edge.
        @(negedge clk);
        set_addr(32'h8);
        mem_read = 1'b1; func3 = 3'b010; byte_enb = 4'b1111;
        mem_write = 1'b1; mem_write_data = 32'h99;
        #1;
        check("rd_before_wr", wb_data, 32'h5);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        #1;
        check("rd_after_wr", wb_data, 32'h99);

        store(32'h10, 32'h80FF7F01, 4'b1111);
        load(32'h10, 3'b000, 4'b0100);
        check("lb_lane2", wb_data, 32'hFFFFFFFF);
        load(32'h10, 3'b000, 4'b0001);
        check("lb_lane0", wb_data, 32'h00000001);
        load(32'h10, 3'b100, 4'b1000);
        check("lbu_lane3", wb_data, 32'h00000080);
        load(32'h10, 3'b001, 4'b1100);
        check("lh_hi", wb_data, 32'hFFFF80FF);
        load(32'h10, 3'b101, 4'b0011);
        check("lhu_lo", wb_data, 32'h00007F01);
        load(32'h10, 3'b011, 4'b1111);
        check("bad_f3_wb", wb_data, 32'h0);
        check("bad_f3_valid", {31'h0, valid}, 32'h0);
        load(32'h10, 3'b000, 4'b0011);
        check("lb_not_onehot", {31'h0, valid}, 32'h0);
        load(32'h10, 3'b001, 4'b0110);
        check("lh_bad_mask", {31'h0, valid}, 32'h0);
        load(32'h10, 3'b010, 4'b0111);
        check("lw_bad_mask", wb_data, 32'h0);

        // Asynchronous reset mid-cycle, with a store attempted while held.
        load(32'h10, 3'b010, 4'b1111);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_wb_zero", wb_data, 32'h0);
        store(32'h10, 32'hDEADBEEF, 4'b1111);
        debug_addr = 12'h010;
        #1;
        check("rst_write_blocked", debug_data, 32'h80FF7F01);
        rst = 1'b1;
        load(32'h10, 3'b010, 4'b1111);
        check("post_rst_w10", wb_data, 32'h80FF7F01);
        load(32'hC, 3'b010, 4'b1111);
        check("post_rst_wC", wb_data, 32'h0000AB05);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
